ex_mdu: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the ALU in the execute stage. It accepts one MUL/DIV/REM-family operation from EX and computes it over multiple cycles, shifting one bit per cycle, while holding the pipeline with a stall. It returns the 32-bit (DATA_WIDTH) result with a one-cycle done pulse. A flush (misprediction) kills an in-flight operation.

---
 rtl/ex_mdu_pkg.sv | 7 +
 rtl/ex_mdu_if.sv | 14 +
 rtl/ex_mdu_iter.sv | 17 +
 rtl/ex_mdu.sv | 97 +++++++++
 tb/tb_ex_mdu.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared op encoding, FSM states and sizing for the RV32M multiply/divide unit
package ex_mdu_pkg;
  localparam int MDU_DW = 32;
  localparam int MDU_CNT_W = $clog2(MDU_DW + 1);
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} mduop_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_t;
endpackage

// File: rtl/ex_mdu_if.sv
// ex_mdu_if: EX-stage request (start/mduop/opr_a/opr_b/flush) and response (stall/done/result) bundle
interface ex_mdu_if #(parameter int DATA_WIDTH = ex_mdu_pkg::MDU_DW);
  import ex_mdu_pkg::*;
  logic start;
  mduop_t mduop;
  logic [DATA_WIDTH-1:0] opr_a;
  logic [DATA_WIDTH-1:0] opr_b;
  logic flush;
  logic stall;
  logic done;
  logic [DATA_WIDTH-1:0] result;
  modport master (output start, mduop, opr_a, opr_b, flush, input stall, done, result);
  modport slave (input start, mduop, opr_a, opr_b, flush, output stall, done, result);
endinterface

// File: rtl/ex_mdu_iter.sv
// ex_mdu_iter: one shift-add (multiply) or restoring shift-subtract (divide) step on the 2W accumulator
module ex_mdu_iter #(parameter int DATA_WIDTH = 32) (
  input  logic                    is_div,
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] acc_nxt
);
  localparam int W = DATA_WIDTH;
  logic [W:0] sum, r, diff;
  always_comb begin
    sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b} : '0);
    r = acc[2*W-1:W-1];
    diff = r - {1'b0, b};
    acc_nxt = is_div ? {diff[W] ? r[W-1:0] : diff[W-1:0], acc[W-2:0], ~diff[W]}
                     : {sum, acc[W-1:1]};
  end
endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M mul/div unit with stall/done handshake; EX_MDU_FAST_MUL_EN selects single-cycle multiply
module ex_mdu #(parameter int DATA_WIDTH = ex_mdu_pkg::MDU_DW) (
  input logic clk,
  input logic rst,
  ex_mdu_if.slave bus
);
  import ex_mdu_pkg::*;
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  mdu_state_t state, nxt;
  mduop_t op_q, fin_op;
  logic [CW-1:0] cnt;
  logic [W-1:0] b_q, mag_a, mag_b, quo, rem, res_d, result;
  logic [2*W-1:0] acc, acc_nxt, ld_acc, fin_acc, prod;
  logic neg_hi, neg_r, ld_nh, ld_nr, sa, sb, go_done, fin_nh, fin_nr, accept;
`ifdef EX_MDU_FAST_MUL_EN
  logic signed [2*W-1:0] fa, fb;
`endif
  ex_mdu_iter #(.DATA_WIDTH(W)) u_iter (.is_div(op_q[2]), .acc(acc), .b(b_q), .acc_nxt(acc_nxt));
  always_comb begin
    sa = !(bus.mduop inside {MULHU, DIVU, REMU}) && bus.opr_a[W-1];
    sb = (bus.mduop inside {MUL, MULH, DIV, REM}) && bus.opr_b[W-1];
    mag_a = sa ? -bus.opr_a : bus.opr_a;
    mag_b = sb ? -bus.opr_b : bus.opr_b;
    ld_acc = {{W{1'b0}}, mag_a};
    ld_nh = sa ^ sb;
    ld_nr = sa;
    go_done = 1'b0;
`ifdef EX_MDU_FAST_MUL_EN
    fa = $signed({sa, bus.opr_a});
    fb = $signed({sb, bus.opr_b});
`endif
    if (bus.mduop[2] && bus.opr_b == '0) begin
      ld_acc = {bus.opr_a, {W{1'b1}}};
      ld_nh = 1'b0;
      ld_nr = 1'b0;
      go_done = 1'b1;
    end else if ((bus.mduop inside {DIV, REM}) && bus.opr_a == {1'b1, {(W-1){1'b0}}} && &bus.opr_b) begin
      ld_acc = {{W{1'b0}}, bus.opr_a};
      ld_nh = 1'b0;
      ld_nr = 1'b0;
      go_done = 1'b1;
    end
`ifdef EX_MDU_FAST_MUL_EN
    else if (!bus.mduop[2]) begin
      ld_acc = fa * fb;
      ld_nh = 1'b0;
      ld_nr = 1'b0;
      go_done = 1'b1;
    end
`endif
  end
  always_comb begin
    fin_op = state == IDLE ? bus.mduop : op_q;
    fin_acc = state == CALC ? acc_nxt : ld_acc;
    fin_nh = state == CALC ? neg_hi : ld_nh;
    fin_nr = state == CALC ? neg_r : ld_nr;
    prod = fin_nh ? -fin_acc : fin_acc;
    quo = fin_nh ? -fin_acc[W-1:0] : fin_acc[W-1:0];
    rem = fin_nr ? -fin_acc[2*W-1:W] : fin_acc[2*W-1:W];
    res_d = !fin_op[2] ? (fin_op == MUL ? prod[W-1:0] : prod[2*W-1:W]) : (fin_op[1] ? rem : quo);
    accept = state == IDLE && bus.start && !bus.flush;
    nxt = bus.flush ? IDLE
        : state == IDLE ? (bus.start ? (go_done ? DONE : CALC) : IDLE)
        : state == CALC ? (cnt == CW'(1) ? DONE : CALC)
        : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= MUL;
      cnt <= '0;
      b_q <= '0;
      acc <= '0;
      neg_hi <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_q <= bus.mduop;
        b_q <= mag_b;
        acc <= ld_acc;
        neg_hi <= ld_nh;
        neg_r <= ld_nr;
        cnt <= CW'(W);
      end else if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt - 1'b1;
      end
      if (nxt == DONE) result <= res_d;
    end
  end
  assign bus.stall = (state == IDLE && bus.start) || state == CALC;
  assign bus.done = state == DONE;
  assign bus.result = result;
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed-vector self-checking bench for ex_mdu latency, results, flush and reset
module tb_ex_mdu;
  import ex_mdu_pkg::*;
`ifdef EX_MDU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  ex_mdu_if bus();
  ex_mdu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input mduop_t op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, output int dc);
    int t0;
    logic bad;
    bus.mduop = op;
    bus.opr_a = a;
    bus.opr_b = b;
    bus.start = 1'b1;
    t0 = cyc;
    bad = 1'b0;
    dc = -1;
    for (int k = 0; k < 100 && dc < 0; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dc = cyc;
        bad = bad | bus.stall;
        check({tag, " res"}, bus.result, exp);
      end else bad = bad | !bus.stall;
      @(posedge clk);
      #1;
      bus.opr_a = ~a;
      bus.opr_b = a ^ b ^ 32'h5a5a_1234;
      bus.mduop = mduop_t'(op ^ 3'd5);
    end
    bus.start = 1'b0;
    check({tag, " lat"}, 32'(dc - t0), 32'(lat));
    check({tag, " stall"}, 32'(bad), 32'd0);
  endtask
  initial begin
    int dc, d2, t0;
    logic seen;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.mduop = MUL;
    bus.opr_a = '0;
    bus.opr_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    run("div neg", DIV, 32'hFFFF_FFEC, 32'h6, 32'hFFFF_FFFD, 33, dc);
    run("rem neg", REM, 32'hFFFF_FFEC, 32'h6, 32'hFFFF_FFFE, 33, dc);
    run("div negb", DIV, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 33, dc);
    run("rem negb", REM, 32'd20, 32'hFFFF_FFFA, 32'd2, 33, dc);
    run("divu", DIVU, 32'd100, 32'd7, 32'd14, 33, dc);
    run("remu", REMU, 32'd100, 32'd7, 32'd2, 33, dc);
    run("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML, dc);
    run("mul", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, ML, dc);
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML, dc);
    run("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML, dc);
    run("mul lo", MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, ML, dc);
    run("divu0", DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, dc);
    run("remu0", REMU, 32'h1234, 32'h0, 32'h1234, 1, dc);
    run("div0", DIV, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, dc);
    run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, dc);
    run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, dc);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen = seen | bus.done | bus.stall;
    end
    check("no reaccept", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    bus.mduop = DIV;
    bus.opr_a = 32'd100;
    bus.opr_b = 32'd7;
    bus.start = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    while (cyc < t0 + 10) begin
      @(negedge clk);
      seen = seen | bus.done;
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    seen = seen | bus.done;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("flush stall", 32'(bus.stall), 32'd0);
    check("flush done", 32'(seen | bus.done), 32'd0);
    check("flush result", bus.result, 32'h8000_0000);
    run("mul flush", MUL, 32'd7, 32'd6, 32'h2A, ML, dc);
    check("mul flush cyc", 32'(dc - t0), 32'(11 + ML));
    bus.mduop = MUL;
    bus.opr_a = 32'd3;
    bus.opr_b = 32'd3;
    bus.start = 1'b1;
    t0 = cyc;
    while (cyc < t0 + 5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst mid result", bus.result, 32'd0);
    check("rst mid done", 32'(bus.done), 32'd0);
    check("rst mid stall1", 32'(bus.stall), 32'd1);
    bus.start = 1'b0;
    #1;
    check("rst mid stall0", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    run("b2b 1", MUL, 32'd3, 32'd5, 32'hF, ML, dc);
    run("b2b 2", MUL, 32'hFFFF, 32'hFFFF, 32'hFFFE_0001, ML, d2);
    check("b2b cyc1", 32'(dc - t0), 32'(ML));
    check("b2b cyc2", 32'(d2 - t0), 32'(2 * ML + 1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
